// File: rtl/stream_pkg.sv
// stream_pkg: constants and helpers shared by the stream-input blocks.
//   STREAM_DATA_WIDTH : default payload width of the sample stream
//   ptr_width(depth)  : FIFO pointer width, meaning address bits plus one wrap bit
package stream_pkg;
  localparam int STREAM_DATA_WIDTH = 8;

  function automatic int ptr_width(int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/stream_fifo_mem.sv
// stream_fifo_mem: FIFO storage with a registered write port and a
// combinational read port. The array is kept as the single named object
// `mem` so that cocotb and VCD dumps can reach it. Contents are not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read data
module stream_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int AW         = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/stream_in_fifo.sv
// stream_in_fifo: first-word-fall-through FIFO that feeds the sample stream
// consumer. It exposes occupancy and flags so the test can observe them.
//   clk, reset       : clock and synchronous active-high reset
//   flush            : synchronous discard of all contents
//   s_valid/s_ready/s_data : upstream side
//   m_valid/m_ready/m_data : consumer side (stream_in_*)
//   level, full, empty     : registered occupancy and flags
//   overflow               : sticky, set on s_valid while full, cleared by reset only
module stream_in_fifo
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = STREAM_DATA_WIDTH,
  parameter int DEPTH      = 4,
  localparam int LW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [LW-1:0]         level,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow
);
  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;

  // The flags depend on the pointers alone. Neither s_valid nor m_ready
  // feeds s_ready or m_valid, so no ready/valid loop can form.
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty   = (wr_ptr == rd_ptr);
  assign s_ready = !full && !reset;
  assign m_valid = !empty;

  assign push = s_valid && s_ready;
  assign pop  = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (s_valid && full) overflow <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop)      level <= level + LW'(1);
        else if (pop && !push) level <= level - LW'(1);
      end
    end
  end

  // A write that coincides with a flush is dropped. The pointer would be
  // reset anyway, and suppressing it keeps the dump clean.
  stream_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push && !flush),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (s_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (m_data)
  );
endmodule

// File: tb/tb_stream_in_fifo.sv
module tb_stream_in_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset, flush, s_valid, s_ready, m_valid, m_ready;
  logic [DW-1:0] s_data, m_data;
  logic [LW-1:0] level;
  logic          full, empty, overflow;

  int total = 0;
  int bad   = 0;

  // reference model: the FIFO is a queue plus a sticky flag
  logic [DW-1:0] q[$];
  logic          m_ovf;

  always #5 clk = ~clk;

  stream_in_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .level    (level),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive the inputs and check the outputs against the model.
  // Then step the model through the coming rising edge.
  task automatic cyc(input logic rst, input logic fl, input logic sv,
                     input logic [DW-1:0] sd, input logic mr);
    bit m_full, m_empty, do_push, do_pop;
    @(negedge clk);
    reset = rst; flush = fl; s_valid = sv; s_data = sd; m_ready = mr;
    #1;
    m_full  = (q.size() == DEPTH);
    m_empty = (q.size() == 0);
    chk("level",    32'(level),    q.size());
    chk("full",     32'(full),     32'(m_full));
    chk("empty",    32'(empty),    32'(m_empty));
    chk("m_valid",  32'(m_valid),  32'(!m_empty));
    chk("s_ready",  32'(s_ready),  32'(!m_full && !rst));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (!m_empty) chk("m_data", 32'(m_data), 32'(q[0]));
    do_push = sv && !m_full && !rst;
    do_pop  = !m_empty && mr;
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      if (sv && m_full) m_ovf = 1'b1;
      if (fl) q.delete();
      else begin
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back(sd);
      end
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    m_ovf = 1'b0;
    repeat (2) @(posedge clk);

    // reset then idle
    cyc(0, 0, 0, 8'h00, 0);
    chk("idle_sready", 32'(s_ready), 1);
    chk("idle_mvalid", 32'(m_valid), 0);

    // fill, then overflow attempt, then drain
    cyc(0, 0, 1, 8'h11, 0);
    cyc(0, 0, 1, 8'h22, 0);
    cyc(0, 0, 1, 8'h33, 0);
    cyc(0, 0, 1, 8'h44, 0);
    cyc(0, 0, 1, 8'h55, 0);
    chk("fill_full",  32'(full),  1);
    chk("fill_level", 32'(level), 4);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 8'h00, 1);
    chk("drained_empty", 32'(empty),    1);
    chk("ovf_sticky",    32'(overflow), 1);
    cyc(1, 0, 0, 8'h00, 0);
    cyc(0, 0, 0, 8'h00, 0);
    chk("ovf_cleared", 32'(overflow), 0);

    // streaming across the pointer wrap
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 8'(i), 1);
    chk("stream_level", 32'(level), 1);
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 8'h00, 1);

    // flush mid-burst with a coincident push
    cyc(0, 0, 1, 8'hA1, 0);
    cyc(0, 0, 1, 8'hA2, 0);
    cyc(0, 0, 1, 8'hA3, 0);
    cyc(0, 1, 1, 8'h99, 1);
    cyc(0, 0, 0, 8'h00, 1);
    chk("flush_level", 32'(level), 0);
    chk("flush_empty", 32'(empty), 1);
    cyc(0, 0, 0, 8'h00, 1);

    // reset mid-operation
    cyc(0, 0, 1, 8'hB1, 0);
    cyc(0, 0, 1, 8'hB2, 0);
    cyc(1, 0, 1, 8'hB3, 1);
    cyc(0, 0, 0, 8'h00, 0);
    chk("rstmid_level",  32'(level),   0);
    chk("rstmid_mvalid", 32'(m_valid), 0);

    // randomized traffic
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(60) == 0), ($urandom_range(25) == 0),
          ($urandom_range(3) != 0), 8'($urandom), ($urandom_range(2) != 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
